// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// Holds the FSM state encoding and the default block-offset width.
package dcache_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      EVICT  = 3'd2,
      FILL   = 3'd3,
      RESP   = 3'd4
   } state_t;

   localparam int DEFAULT_OFFSET_W = 3;

   function automatic int index_width(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_width(input int addr_w, input int offset_w, input int sets);
      return addr_w - offset_w - $clog2(sets);
   endfunction

   // A single-way cache still needs a 1-bit way select to keep port widths legal.
   function automatic int way_width(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set age counters: the accessed way becomes youngest, the oldest way is the victim.
// Direct-mapped builds (WAYS=1) keep no state and always name way 0.
module dcache_lru #(
   parameter int SETS  = 16,
   parameter int WAYS  = 2,
   parameter int IDX_W = 4,
   parameter int WAY_W = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             update,
   input  logic [IDX_W-1:0] update_set,
   input  logic [WAY_W-1:0] update_way,
   input  logic [IDX_W-1:0] victim_set,
   output logic [WAY_W-1:0] victim_way
);

   generate
      if (WAYS == 1) begin : g_direct
         assign victim_way = '0;
      end else begin : g_lru
         localparam int AGE_W = $clog2(WAYS);
         localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

         logic [AGE_W-1:0] age [SETS][WAYS];
         logic [WAY_W-1:0] best_way;

         // Ways no older than the touched one age by one; ties after reset resolve toward way 0.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int s = 0; s < SETS; s++)
                  for (int w = 0; w < WAYS; w++)
                     age[s][w] <= '0;
            end else if (update) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (WAY_W'(w) == update_way)
                     age[update_set][w] <= '0;
                  else if (age[update_set][w] <= age[update_set][update_way] &&
                           age[update_set][w] != AGE_MAX)
                     age[update_set][w] <= age[update_set][w] + 1'b1;
               end
            end
         end

         always_comb begin
            best_way = '0;
            for (int w = 1; w < WAYS; w++)
               if (age[victim_set][w] > age[victim_set][best_way])
                  best_way = WAY_W'(w);
         end

         assign victim_way = best_way;
      end
   endgenerate

endmodule

// File: rtl/assoc_data_cache.sv
// Write-back, write-allocate set-associative data cache, one word per line.
// Define DCACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module assoc_data_cache
   import dcache_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int SETS     = 16,
   parameter int WAYS     = 2,
   parameter int OFFSET_W = DEFAULT_OFFSET_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [2:0]        fsm_state
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int IDX_W = index_width(SETS);
   localparam int TAG_W = tag_width(ADDR_W, OFFSET_W, SETS);
   localparam int WAY_W = way_width(WAYS);

   state_t state, next_state;

   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;

   logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
   logic [DATA_W-1:0] data_arr  [SETS][WAYS];
   logic [WAYS-1:0]   valid_arr [SETS];
   logic [WAYS-1:0]   dirty_arr [SETS];

   logic              hit, found_invalid, victim_dirty, mem_done, lru_update;
   logic [WAY_W-1:0]  hit_way, victim_sel, lru_victim, vict_way_q, lru_way;
   logic [DATA_W-1:0] hit_word, fill_word;

   assign req_idx  = req_addr[OFFSET_W +: IDX_W];
   assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
   assign mem_done = mem_req && mem_ack;

   // Victim: lowest-numbered invalid way first, otherwise the oldest way.
   always_comb begin
      hit           = 1'b0;
      hit_way       = '0;
      found_invalid = 1'b0;
      victim_sel    = lru_victim;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_arr[req_idx][w] && !found_invalid) begin
            found_invalid = 1'b1;
            victim_sel    = WAY_W'(w);
         end
      end
   end

   assign victim_dirty = valid_arr[req_idx][victim_sel] && dirty_arr[req_idx][victim_sel];
   assign hit_word     = req_we ? req_wdata : data_arr[req_idx][hit_way];
   assign fill_word    = req_we ? req_wdata : mem_rdata;

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (cpu_req) next_state = LOOKUP;
         LOOKUP:  next_state = hit ? IDLE : (victim_dirty ? EVICT : FILL);
         EVICT:   if (mem_done) next_state = FILL;
         FILL:    if (mem_done) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   assign cpu_ready = (state == LOOKUP && hit) || state == RESP;
   assign cpu_rdata = (state == LOOKUP && hit) ? hit_word : rdata_q;
   assign fsm_state = state;

   // Control state and memory-port registers; mem_* only change when a request starts.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_we     <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         rdata_q    <= '0;
         vict_way_q <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_arr[s] <= '0;
            dirty_arr[s] <= '0;
         end
      end else begin
         if (state == IDLE && cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
         end
         if (state == LOOKUP) begin
            if (hit) begin
               rdata_q <= hit_word;
               if (req_we) dirty_arr[req_idx][hit_way] <= 1'b1;
            end else begin
               vict_way_q <= victim_sel;
            end
         end
         if (state == FILL && mem_done) begin
            valid_arr[req_idx][vict_way_q] <= 1'b1;
            dirty_arr[req_idx][vict_way_q] <= req_we;
            rdata_q                        <= fill_word;
         end
         mem_req <= (next_state == EVICT) || (next_state == FILL);
         if (state == LOOKUP && next_state == EVICT) begin
            mem_we    <= 1'b1;
            mem_addr  <= {tag_arr[req_idx][victim_sel], req_idx, {OFFSET_W{1'b0}}};
            mem_wdata <= data_arr[req_idx][victim_sel];
         end else if (state != FILL && next_state == FILL) begin
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (state == LOOKUP && hit && req_we)
         data_arr[req_idx][hit_way] <= req_wdata;
      if (state == FILL && mem_done) begin
         tag_arr[req_idx][vict_way_q]  <= req_tag;
         data_arr[req_idx][vict_way_q] <= fill_word;
      end
   end

   assign lru_update = (state == LOOKUP && hit) || (state == FILL && mem_done);
   assign lru_way    = (state == LOOKUP) ? hit_way : vict_way_q;

   dcache_lru #(
      .SETS  (SETS),
      .WAYS  (WAYS),
      .IDX_W (IDX_W),
      .WAY_W (WAY_W)
   ) u_lru (
      .clock      (clock),
      .reset_n    (reset_n),
      .update     (lru_update),
      .update_set (req_idx),
      .update_way (lru_way),
      .victim_set (req_idx),
      .victim_way (lru_victim)
   );

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == LOOKUP) begin
         if (hit) begin
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_assoc_data_cache.sv
// Scoreboarded bench for assoc_data_cache (SETS=16, WAYS=2) with a delay-programmable memory.
// Stats checks compile in when DCACHE_STATS_EN is defined.
module tb_assoc_data_cache;

   localparam int K_HIT   = 0;
   localparam int K_MISS  = 1;
   localparam int K_EVICT = 2;

   logic        clock, reset_n;
   logic        cpu_req, cpu_we, cpu_ready;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  fsm_state;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   assoc_data_cache dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .fsm_state (fsm_state)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   // ---------------- clock ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [71:0] exp_mem_q[$];
   logic [31:0] mem_model [logic [31:0]];
   int          ack_delay = 3;
   bit          pulse_evict = 1'b0;
   bit          pulse_pending = 1'b0;

   task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [71:0] txn(input logic we, input logic [31:0] a, input logic [31:0] d);
      return {7'b0, we, a, (we ? d : 32'h0)};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   task automatic push_rd(input logic [31:0] a);
      exp_mem_q.push_back(txn(1'b0, a, 32'h0));
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      exp_mem_q.push_back(txn(1'b1, a, d));
   endtask

   // ---------------- memory model ----------------
   initial begin : mem_model_proc
      bit          busy;
      int          cnt;
      logic        cap_we;
      logic [31:0] cap_addr, cap_wdata;
      busy      = 1'b0;
      cnt       = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clock);
         mem_ack = 1'b0;
         if (pulse_pending) begin
            cpu_req       = 1'b0;
            pulse_pending = 1'b0;
         end
         if (mem_req) begin
            if (!busy) begin
               busy      = 1'b1;
               cnt       = 0;
               cap_we    = mem_we;
               cap_addr  = mem_addr;
               cap_wdata = mem_wdata;
               if (exp_mem_q.size() == 0)
                  check("mem_unexpected", txn(mem_we, mem_addr, mem_wdata), 72'h0);
               else
                  check("mem_txn", txn(mem_we, mem_addr, mem_wdata), exp_mem_q.pop_front());
               if (mem_we && pulse_evict) begin
                  cpu_req       = 1'b1;
                  cpu_we        = 1'b1;
                  cpu_addr      = 32'h0000_0900;
                  pulse_pending = 1'b1;
                  pulse_evict   = 1'b0;
               end
            end else begin
               check("mem_stable", {mem_we, mem_addr, mem_wdata}, {cap_we, cap_addr, cap_wdata});
            end
            if (cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = cap_we ? 32'h0 : mem_word(cap_addr);
               if (cap_we) mem_model[cap_addr] = cap_wdata;
               busy = 1'b0;
            end else begin
               cnt++;
            end
         end else begin
            busy = 1'b0;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int kind, input logic [31:0] exp_data);
      int cycles;
      int exp_cycles;
      exp_q.push_back(exp_data);
      exp_cycles = (kind == K_HIT) ? 1 : (kind == K_MISS) ? ack_delay + 3 : 2 * ack_delay + 4;
      @(negedge clock);
      check("idle_before", fsm_state, 3'd0);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(posedge clock);
      #1 cpu_req = 1'b0;
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!cpu_ready && cycles < 100);
      if (!cpu_ready) begin
         check("ready_timeout", cycles, exp_cycles);
         exp_q.delete();
      end else begin
         check("latency", cycles, exp_cycles);
         check("rdata", cpu_rdata, exp_q.pop_front());
         @(negedge clock);
         check("ready_pulse", cpu_ready, 1'b0);
         check("rdata_hold", cpu_rdata, exp_data);
         check("mem_txn_left", exp_mem_q.size(), 0);
      end
   endtask

   // ---------------- main sequence ----------------
   int          cycles;
   logic [31:0] w1, w2, w3;

   initial begin
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      reset_n   = 1'b1;
      mem_model[32'h0000_0500] = 32'h0101_0101;
      w1 = $urandom;
      w2 = $urandom;
      w3 = $urandom;

      #2 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_ready", cpu_ready, 1'b0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_state", fsm_state, 3'd0);
      reset_n = 1'b1;

      // cold miss, hit, write hit, read back
      ack_delay = 3;
      push_rd(32'h500);
      cpu_access(1'b0, 32'h500, 32'h0, K_MISS, 32'h0101_0101);
      cpu_access(1'b0, 32'h500, 32'h0, K_HIT, 32'h0101_0101);
`ifdef DCACHE_STATS_EN
      check("hit_count", hit_count, 32'd1);
      check("miss_count", miss_count, 32'd1);
`endif
      cpu_access(1'b1, 32'h500, 32'hDEAD_BEEF, K_HIT, 32'hDEAD_BEEF);
      cpu_access(1'b0, 32'h500, 32'h0, K_HIT, 32'hDEAD_BEEF);

      // fill second way, then evict the dirty LRU line
      push_rd(32'h580);
      cpu_access(1'b0, 32'h580, 32'h0, K_MISS, mem_word(32'h580));
      push_wr(32'h500, 32'hDEAD_BEEF);
      push_rd(32'h600);
      cpu_access(1'b0, 32'h600, 32'h0, K_EVICT, mem_word(32'h600));
      push_rd(32'h500);
      cpu_access(1'b0, 32'h500, 32'h0, K_MISS, 32'hDEAD_BEEF);

      // dirty both ways, evict with slow ack and a stray cpu_req during EVICT
      ack_delay = 0;
      cpu_access(1'b1, 32'h600, w1, K_HIT, w1);
      cpu_access(1'b1, 32'h500, w2, K_HIT, w2);
      ack_delay   = 5;
      pulse_evict = 1'b1;
      push_wr(32'h600, w1);
      push_rd(32'h680);
      cpu_access(1'b0, 32'h680, 32'h0, K_EVICT, mem_word(32'h680));
      repeat (3) @(negedge clock);
      check("pulse_state", fsm_state, 3'd0);
      check("pulse_ready", cpu_ready, 1'b0);
      check("pulse_mem_left", exp_mem_q.size(), 0);

      // zero-delay eviction, then refetch the written-back word
      ack_delay = 0;
      push_wr(32'h500, w2);
      push_rd(32'h700);
      cpu_access(1'b0, 32'h700, 32'h0, K_EVICT, mem_word(32'h700));
      ack_delay = 2;
      push_rd(32'h600);
      cpu_access(1'b0, 32'h600, 32'h0, K_MISS, w1);

      // write-allocate on another set and write-back of that line
      ack_delay = $urandom_range(0, 4);
      push_rd(32'h508);
      cpu_access(1'b1, 32'h508, w3, K_MISS, w3);
      cpu_access(1'b0, 32'h508, 32'h0, K_HIT, w3);
      push_rd(32'h588);
      cpu_access(1'b0, 32'h588, 32'h0, K_MISS, mem_word(32'h588));
      push_wr(32'h508, w3);
      push_rd(32'h608);
      cpu_access(1'b0, 32'h608, 32'h0, K_EVICT, mem_word(32'h608));

      // asynchronous reset while FILL waits for an ack that never comes
      ack_delay = 1000;
      push_rd(32'h710);
      @(negedge clock);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h710;
      @(posedge clock);
      #1 cpu_req = 1'b0;
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!mem_req && cycles < 20);
      check("fill_started", mem_req, 1'b1);
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("async_mem_req", mem_req, 1'b0);
      check("async_state", fsm_state, 3'd0);
      check("async_ready", cpu_ready, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      check("abort_mem_left", exp_mem_q.size(), 0);
      ack_delay = 1;
      push_rd(32'h710);
      cpu_access(1'b0, 32'h710, 32'h0, K_MISS, mem_word(32'h710));
`ifdef DCACHE_STATS_EN
      check("hit_after_rst", hit_count, 32'd0);
      check("miss_after_rst", miss_count, 32'd1);
      force dut.hit_count = 32'hFFFF_FFFF;
      @(negedge clock);
      release dut.hit_count;
      cpu_access(1'b0, 32'h710, 32'h0, K_HIT, mem_word(32'h710));
      check("hit_saturate", hit_count, 32'hFFFF_FFFF);
`endif

      repeat (2) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/assoc_data_cache.md
ASSOC_DATA_CACHE -- requirements
Module: assoc_data_cache

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, word width; one word per line.
REQ-003 Parameter SETS, default 16, set count; power of 2, at least 2.
REQ-004 Parameter WAYS, default 2, associativity; 1, 2 or 4.
REQ-005 Parameter OFFSET_W, default 3, block-offset bits; ignored for lookup (8-byte address stride).
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 cpu_req  in  1  access request, sampled in IDLE only.
REQ-009 cpu_we  in  1  1 = write, 0 = read.
REQ-010 cpu_addr  in  ADDR_W  byte address.
REQ-011 cpu_wdata  in  DATA_W  write data.
REQ-012 cpu_rdata  out  DATA_W  read data, or written data on writes.
REQ-013 cpu_ready  out  1  one-cycle completion pulse.
REQ-014 mem_req, mem_we  out  1 each  backing-memory request and direction.
REQ-015 mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  backing-memory address and data.
REQ-016 mem_rdata  in  DATA_W, mem_ack  in  1  fill data and completion.

Function
REQ-017 index = addr[OFFSET_W +: log2(SETS)]; tag = the remaining upper bits.
REQ-018 FSM states: IDLE, LOOKUP, EVICT, FILL, RESP.
REQ-019 In IDLE with cpu_req=1: latch addr, we and wdata, then go to LOOKUP.
  - cpu_req is ignored in every other state.
REQ-020 LOOKUP hit:
  - read: cpu_rdata = line data.
  - write: line data = wdata, dirty = 1, cpu_rdata = wdata.
  - cpu_ready = 1 in the LOOKUP cycle, then IDLE; hit latency is 1 cycle after acceptance.
REQ-021 LOOKUP miss, victim choice: lowest-numbered invalid way; otherwise the LRU way.
  - Victim valid and dirty -> EVICT; else -> FILL.
REQ-022 EVICT:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, OFFSET_W'0}, mem_wdata=victim data.
  - On mem_ack -> FILL.
REQ-023 FILL:
  - mem_req=1, mem_we=0, mem_addr={tag, index, OFFSET_W'0}.
  - On mem_ack: install mem_rdata, valid=1, dirty=0.
  - Write miss: merge wdata and set dirty=1 (write-allocate).
  - Then RESP.
REQ-024 RESP: cpu_ready=1, cpu_rdata = installed word; next state IDLE; miss latency = memory cycles + 2.
REQ-025 mem_* outputs are held stable while mem_req=1 and until mem_ack is sampled.
  - mem_req deasserts in the cycle after mem_ack.
  - mem_ack while mem_req=0 is ignored.
REQ-026 LRU: every hit and every fill makes the accessed way MRU; per-way age counters of log2(WAYS) bits; WAYS=1 has no LRU state.
REQ-027 cpu_rdata holds its last value between responses.

Reset
REQ-028 reset_n low asynchronously:
  - clears all valid, dirty and LRU state.
  - sets state to IDLE.
  - zeroes cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr and mem_wdata.
REQ-029 Reset mid-EVICT or mid-FILL: mem_req drops immediately, the pending access is discarded, and no line is installed.

Configuration
REQ-030 Macro DCACHE_STATS_EN defined:
  - ports hit_count and miss_count (out, 32 each) exist.
  - Each increments once per LOOKUP outcome and saturates at 32'hFFFF_FFFF.
  - Both clear on reset.
REQ-031 Macro DCACHE_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

Structure
REQ-032 Package dcache_pkg holds the FSM state enum, the default OFFSET_W, and tag/index width helper functions.
REQ-033 Sub-module dcache_lru holds per-set age counters: update(set, way) and victim(set) outputs; the tag/data/valid/dirty arrays stay in the top module.

Verification (SETS=16, WAYS=2)
REQ-034 Read 0x0000_0500 after reset:
  - mem read at 0x500; mem_rdata 0x0101_0101 with ack after 3 cycles.
  - cpu_ready with cpu_rdata 0x0101_0101.
  - Re-read: hit, cpu_ready one cycle after acceptance, no mem_req.
REQ-035 Write 0x500 = 0xDEAD_BEEF (hit): no mem traffic; a subsequent read returns 0xDEAD_BEEF.
REQ-036 Then read 0x580, then read 0x600 (all index 0):
  - the second miss evicts the 0x500 line: mem write to 0x500 with 0xDEAD_BEEF, then a fill from 0x600.
  - Re-read 0x500 misses.
REQ-037 reset_n low during FILL with mem_ack withheld: mem_req goes 0 without waiting for a clock; a read of the same address afterwards misses.
REQ-038 cpu_req pulsed during EVICT is ignored. With mem_ack delays of 0 and 5 cycles, mem_addr and mem_wdata stay stable while mem_req=1.
REQ-039 DCACHE_STATS_EN defined, after REQ-034: hit_count=1, miss_count=1.
  - With the counter forced to 32'hFFFF_FFFF, a further hit leaves it unchanged.
